// File: rtl/cross_pulse_recover_pkg.sv
// Shared FSM encoding and sizing helper for the pulse-recovery block.
package cross_pulse_recover_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_QUAL = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Bits needed to count up to min_len active samples.
    function automatic int wcnt_width(input int min_len);
        return (min_len < 1) ? 1 : $clog2(min_len + 1);
    endfunction

endpackage

// File: rtl/evt_sat_counter.sv
// Saturating pending-event counter with valid/ready drain and sticky overflow.
// Latency: count/valid/overflow update one cycle after inc or accepted dequeue.
module evt_sat_counter
    import cross_pulse_recover_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             deq_rdy,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             dec;
    logic             full;

    // A ready with nothing pending is not a dequeue.
    assign dec  = valid_q & deq_rdy;
    assign full = (count_q == CNT_MAX);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end
        if (inc && !dec) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (!inc && dec) begin
            count_d = count_q - CNT_W'(1);
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/cross_pulse_recover.sv
// Qualifies a synchronised stretched level by minimum width, emits one pulse per event, queues events.
// Latency: pulse in the cycle after the MIN_LEN-th active sample; pending follows one cycle later.
module cross_pulse_recover
    import cross_pulse_recover_pkg::*;
#(
    parameter     PHASE   = "POSITIVE",
    parameter int MIN_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             d,
    output logic             pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pending,
    output logic             glitch,
    output logic             overflow,
    input  logic             clr_err
);

    localparam int WCNT_W   = wcnt_width(MIN_LEN);
    localparam bit ACT_HIGH = (PHASE == "POSITIVE");

    logic              act;
    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pulse_q, pulse_d;
    logic              glitch_q, glitch_d;

    assign act = ACT_HIGH ? d : ~d;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pulse_d  = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            // A level already active when reset lifts is not a new event.
            ST_ARM: begin
                if (!act) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (act) begin
                    if (MIN_LEN == 1) begin
                        state_d = ST_HOLD;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = ST_QUAL;
                        wcnt_d  = WCNT_W'(1);
                    end
                end
            end
            ST_QUAL: begin
                if (act) begin
                    if (int'(wcnt_q) + 1 == MIN_LEN) begin
                        state_d = ST_HOLD;
                        pulse_d = 1'b1;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end else begin
                    state_d  = ST_IDLE;
                    glitch_d = 1'b1;
                    wcnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (!act) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_ARM;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARM;
            wcnt_q   <= '0;
            pulse_q  <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pulse_q  <= pulse_d;
            glitch_q <= glitch_d;
        end
    end

    assign pulse  = pulse_q;
    assign glitch = glitch_q;

    evt_sat_counter #(
        .CNT_W (CNT_W)
    ) u_evt_cnt (
        .clock    (clock),
        .rst_n    (rst_n),
        .inc      (pulse_q),
        .deq_rdy  (evt_ready),
        .clr      (clr_err),
        .count    (pending),
        .valid    (evt_valid),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_cross_pulse_recover.sv
// Randomised bench: run-length reference model feeding pulse/glitch scoreboards plus queue-state checks.
module tb_cross_pulse_recover;

    localparam int MIN_LEN = 3;
    localparam int CNT_W   = 2;
    localparam int CAP     = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             d = 1'b1;
    logic             d_n;
    logic             evt_ready = 1'b0;
    logic             clr_err = 1'b0;

    logic             pulse_a, evt_valid_a, glitch_a, overflow_a;
    logic [CNT_W-1:0] pending_a;
    logic             pulse_b, evt_valid_b, glitch_b, overflow_b;
    logic [CNT_W-1:0] pending_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    int cyc     = 0;
    bit armed   = 1'b0;
    int run     = 0;
    bit m_pulse = 1'b0;
    bit m_glitch = 1'b0;
    int m_pend  = 0;
    bit m_ovf   = 1'b0;
    int pq[$];
    int gq[$];

    assign d_n = ~d;

    cross_pulse_recover #(.PHASE("POSITIVE"), .MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut_a (
        .clock(clock), .rst_n(rst_n), .d(d), .pulse(pulse_a), .evt_valid(evt_valid_a),
        .evt_ready(evt_ready), .pending(pending_a), .glitch(glitch_a),
        .overflow(overflow_a), .clr_err(clr_err)
    );

    cross_pulse_recover #(.PHASE("NEGATIVE"), .MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut_b (
        .clock(clock), .rst_n(rst_n), .d(d_n), .pulse(pulse_b), .evt_valid(evt_valid_b),
        .evt_ready(evt_ready), .pending(pending_b), .glitch(glitch_b),
        .overflow(overflow_b), .clr_err(clr_err)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        armed    = 1'b0;
        run      = 0;
        m_pulse  = 1'b0;
        m_glitch = 1'b0;
        m_pend   = 0;
        m_ovf    = 1'b0;
        pq.delete();
        gq.delete();
    endtask

    // Reference model: events are runs of active samples after the first inactive one.
    initial begin
        bit inc, dec, sat;
        forever begin
            @(posedge clock or negedge rst_n);
            if (clock) cyc++;
            if (!rst_n) begin
                model_reset();
            end else begin
                inc = m_pulse;
                dec = evt_ready && (m_pend != 0);
                sat = inc && !dec && (m_pend == CAP);
                if (inc && !dec && !sat) m_pend++;
                else if (!inc && dec)    m_pend--;
                if (sat)          m_ovf = 1'b1;
                else if (clr_err) m_ovf = 1'b0;

                m_pulse  = 1'b0;
                m_glitch = 1'b0;
                if (d) begin
                    if (armed) begin
                        run++;
                        if (run == MIN_LEN) begin
                            m_pulse = 1'b1;
                            pq.push_back(cyc);
                        end
                    end
                end else begin
                    if (run > 0 && run < MIN_LEN) begin
                        m_glitch = 1'b1;
                        gq.push_back(cyc);
                    end
                    armed = 1'b1;
                    run   = 0;
                end
            end
        end
    end

    // Monitor: pops expected strobes when the DUT presents them; checks queue state every cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (pulse_a) begin
                if (pq.size() == 0) chk("pulse_unexpected", 1, 0);
                else chk("pulse_cycle", cyc, pq.pop_front());
            end
            while (pq.size() > 0 && pq[0] < cyc) begin
                chk("pulse_missed", -1, pq.pop_front());
            end
            if (glitch_a) begin
                if (gq.size() == 0) chk("glitch_unexpected", 1, 0);
                else chk("glitch_cycle", cyc, gq.pop_front());
            end
            while (gq.size() > 0 && gq[0] < cyc) begin
                chk("glitch_missed", -1, gq.pop_front());
            end
            chk("pulse_glitch_excl", int'(pulse_a & glitch_a), 0);
            chk("pending_a", int'(pending_a), m_pend);
            chk("evt_valid_a", int'(evt_valid_a), int'(m_pend != 0));
            chk("overflow_a", int'(overflow_a), int'(m_ovf));
            chk("pulse_b", int'(pulse_b), int'(m_pulse));
            chk("glitch_b", int'(glitch_b), int'(m_glitch));
            chk("pending_b", int'(pending_b), m_pend);
            chk("overflow_b", int'(overflow_b), int'(m_ovf));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic hold_d(input logic val, input int n);
        d = val;
        step(n);
    endtask

    task automatic rcycles(input logic val, input int n);
        repeat (n) begin
            d         = val;
            evt_ready = ($urandom_range(0, 99) < 35);
            clr_err   = ($urandom_range(0, 99) < 4);
            step(1);
        end
    endtask

    initial begin
        // Level held active through reset must not count as an event.
        step(3);
        rst_n = 1'b1;
        hold_d(1'b1, 20);
        chk("armed_no_event", int'(pending_a), 0);
        hold_d(1'b0, 1);
        hold_d(1'b1, 5);
        hold_d(1'b0, 2);
        chk("first_event_pending", int'(pending_a), 1);
        chk("first_event_valid", int'(evt_valid_a), 1);

        // Too-short level is a glitch, queue unchanged.
        hold_d(1'b1, 2);
        hold_d(1'b0, 3);
        chk("glitch_pending", int'(pending_a), 1);

        // Fill to saturation, then one more to overflow.
        repeat (3) begin
            hold_d(1'b1, 4);
            hold_d(1'b0, 2);
        end
        chk("sat_pending", int'(pending_a), CAP);
        chk("sat_overflow", int'(overflow_a), 1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("clr_overflow", int'(overflow_a), 0);

        evt_ready = 1'b1;
        step(5);
        evt_ready = 1'b0;
        chk("drained", int'(pending_a), 0);

        // Pulse and dequeue in the same cycle leave pending unchanged.
        hold_d(1'b1, 4);
        hold_d(1'b0, 2);
        chk("one_pending", int'(pending_a), 1);
        hold_d(1'b1, 3);
        chk("pulse_visible", int'(pulse_a), 1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("coincide_pending", int'(pending_a), 1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("dequeue_last", int'(pending_a), 0);
        hold_d(1'b0, 2);

        for (int i = 0; i < 300; i++) begin
            rcycles(1'b1, $urandom_range(1, 6));
            rcycles(1'b0, $urandom_range(1, 3));
        end
        evt_ready = 1'b0;
        clr_err   = 1'b0;

        // Reset in the middle of a held event clears everything at once.
        hold_d(1'b0, 2);
        hold_d(1'b1, 4);
        hold_d(1'b1, 2);
        chk("pre_reset_pending", int'(pending_a != 0), 1);
        @(negedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_pending_a", int'(pending_a), 0);
        chk("rst_valid_a", int'(evt_valid_a), 0);
        chk("rst_pulse_a", int'(pulse_a), 0);
        chk("rst_overflow_a", int'(overflow_a), 0);
        chk("rst_pending_b", int'(pending_b), 0);
        chk("rst_valid_b", int'(evt_valid_b), 0);
        step(2);
        rst_n = 1'b1;
        hold_d(1'b1, 10);
        chk("post_reset_armed", int'(pending_a), 0);
        hold_d(1'b0, 2);
        hold_d(1'b1, 4);
        hold_d(1'b0, 3);
        chk("post_reset_event", int'(pending_a), 1);

        step(3);
        chk("pulse_queue_empty", pq.size(), 0);
        chk("glitch_queue_empty", gq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
